// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, ALU op codes, FSM states and opcode classes for the multi-cycle MIPS controller.
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  // TRAP uses a fourth state bit so its low three bits alias IDLE on state_dbg.
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3,
    EXEC_MEM = 4'd4, EXEC_BEQ = 4'd5, MEM = 4'd6, WB = 4'd7, TRAP = 4'd8
  } state_e;
  typedef enum logic [1:0] {CLS_R, CLS_MEM, CLS_BEQ, CLS_ILL} op_class_e;
endpackage

// File: rtl/mips_op_decode.sv
// mips_op_decode: combinational opcode classifier shared by the multi-cycle and pipelined cores.
module mips_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_class_e  cls_o,
  output logic       is_store_o,
  output logic       is_load_o,
  output logic       legal_o
);
  assign is_load_o = opcode_i == OP_LW;
  assign is_store_o = opcode_i == OP_SW;
  assign cls_o = (opcode_i == OP_RTYPE) ? CLS_R :
                 (is_load_o || is_store_o) ? CLS_MEM :
                 (opcode_i == OP_BEQ) ? CLS_BEQ : CLS_ILL;
  assign legal_o = cls_o != CLS_ILL;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore-style multi-cycle MIPS control FSM with a ready/request shared memory port.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             rf_we,
  output logic             rf_dst_sel,
  output logic             rf_wdata_sel,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic             busy,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);
  state_e state_q, state_d;
  logic illegal_q, illegal_d, retire;
  logic [CNT_W-1:0] retired_q;
  op_class_e cls;
  logic is_store, is_load, legal;
  mips_op_decode u_dec (
    .opcode_i(opcode),
    .cls_o(cls),
    .is_store_o(is_store),
    .is_load_o(is_load),
    .legal_o(legal)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retire ? retired_q + CNT_W'(1) : retired_q;
    end
  end
  always_comb begin
    state_d = state_q;
    illegal_d = illegal_q;
    retire = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = 1'b0;
    rf_we = 1'b0;
    rf_dst_sel = 1'b0;
    rf_wdata_sel = 1'b0;
    alu_src_b = 1'b0;
    alu_op = ALU_ADD;
    case (state_q)
      IDLE: state_d = run ? FETCH : IDLE;
      FETCH: begin
        mem_req = 1'b1;
        ir_we = mem_ready;
        pc_we = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        if (!legal) begin
          illegal_d = 1'b1;
          state_d = TRAP;
          retire = !ILLEGAL_HALT;
        end else begin
          state_d = (cls == CLS_R) ? EXEC_R : (cls == CLS_MEM) ? EXEC_MEM : EXEC_BEQ;
        end
      end
      EXEC_R: begin
        alu_op = ALU_FUNCT;
        state_d = WB;
      end
      EXEC_MEM: begin
        alu_src_b = 1'b1;
        state_d = MEM;
      end
      EXEC_BEQ: begin
        alu_op = ALU_SUB;
        pc_src = 1'b1;
        pc_we = alu_zero;
        retire = 1'b1;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we = is_store;
        retire = mem_ready && is_store;
        state_d = (mem_ready && !is_store) ? WB : MEM;
      end
      WB: begin
        rf_we = 1'b1;
        rf_dst_sel = !is_load;
        rf_wdata_sel = is_load;
        retire = 1'b1;
      end
      TRAP: state_d = TRAP;
      default: state_d = IDLE;
    endcase
    // run is only looked at on the retirement cycle, so a stop never aborts an instruction.
    if (retire) state_d = run ? FETCH : IDLE;
  end
  assign illegal = illegal_q;
  assign busy = state_q != IDLE && state_q != TRAP;
  assign state_dbg = state_q[2:0];
  assign retired = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed scoreboard bench for the multi-cycle control FSM (trap and NOP variants).
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;
  localparam logic [11:0] MREQ = 12'h001, MWE = 12'h002, MADDR = 12'h004, IRWE = 12'h008;
  localparam logic [11:0] PCWE = 12'h010, PCSRC = 12'h020, RFWE = 12'h040, RFDST = 12'h080;
  localparam logic [11:0] RFWD = 12'h100, ALUB = 12'h200, ILL = 12'h400, BUSY = 12'h800;
  localparam logic [11:0] FI = MREQ | IRWE | PCWE;
  localparam logic [5:0] OP_BAD = 6'b111111;
  typedef struct {
    string tag;
    bit chk;
    bit sel;
    logic [18:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic reset, run, alu_zero, mem_ready;
  logic [5:0] opcode;
  logic [1:0] mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, rf_we, rf_dst_sel;
  logic [1:0] rf_wdata_sel, alu_src_b, illegal, busy;
  logic [1:0] alu_op [2];
  logic [2:0] state_dbg [2];
  logic [1:0] ret_a;
  logic [15:0] ret_b;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;
  always #5 clk = ~clk;
  mips_multicycle_ctrl #(.CNT_W(2), .ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
    .mem_addr_sel(mem_addr_sel[0]), .ir_we(ir_we[0]), .pc_we(pc_we[0]), .pc_src(pc_src[0]),
    .rf_we(rf_we[0]), .rf_dst_sel(rf_dst_sel[0]), .rf_wdata_sel(rf_wdata_sel[0]),
    .alu_src_b(alu_src_b[0]), .alu_op(alu_op[0]), .illegal(illegal[0]), .busy(busy[0]),
    .state_dbg(state_dbg[0]), .retired(ret_a)
  );
  mips_multicycle_ctrl #(.CNT_W(16), .ILLEGAL_HALT(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
    .mem_addr_sel(mem_addr_sel[1]), .ir_we(ir_we[1]), .pc_we(pc_we[1]), .pc_src(pc_src[1]),
    .rf_we(rf_we[1]), .rf_dst_sel(rf_dst_sel[1]), .rf_wdata_sel(rf_wdata_sel[1]),
    .alu_src_b(alu_src_b[1]), .alu_op(alu_op[1]), .illegal(illegal[1]), .busy(busy[1]),
    .state_dbg(state_dbg[1]), .retired(ret_b)
  );
  function automatic logic [18:0] obs(input bit s);
    return {busy[s], illegal[s], alu_src_b[s], rf_wdata_sel[s], rf_dst_sel[s], rf_we[s],
            pc_src[s], pc_we[s], ir_we[s], mem_addr_sel[s], mem_we[s], mem_req[s],
            alu_op[s], state_dbg[s], s ? ret_b[1:0] : ret_a};
  endfunction
  task automatic cyc(input string tag, input logic rst, input logic rn, input logic rdy,
                     input logic z, input logic [5:0] op, input logic [2:0] st,
                     input logic [11:0] f, input logic [1:0] aop, input logic [1:0] ret,
                     input bit chk = 1'b1, input bit sel = 1'b0);
    exp_t e;
    @(negedge clk);
    reset = rst;
    run = rn;
    mem_ready = rdy;
    alu_zero = z;
    opcode = op;
    e.tag = tag;
    e.chk = chk;
    e.sel = sel;
    e.v = {f | ((st != 3'd0) ? BUSY : 12'h000), aop, st, ret};
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk) begin
          checks++;
          assert (obs(e.sel) === e.v)
          else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs(e.sel), e.v);
          end
        end
      end
    end
  end
  initial begin
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $error("FAIL timeout: stimulus did not finish within %0d cycles", n);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end
  initial begin
    cyc("rst0", 1, 0, 0, 0, OP_RTYPE, 0, 0, 0, 0, 0);
    cyc("reset", 1, 0, 0, 0, OP_RTYPE, 0, 0, 0, 0);
    #3;
    checks++;
    if (mem_req[0] !== 1'b0 || state_dbg[0] !== 3'd0 || ret_a !== 2'd0 || illegal[0] !== 1'b0 ||
        ret_b !== 16'd0 || busy !== 2'b00) begin
      errors++;
      $error("FAIL reset_state: mem_req=%b state=%0d retired=%0d illegal=%b",
             mem_req[0], state_dbg[0], ret_a, illegal[0]);
    end
    cyc("idle_hold", 0, 0, 1, 0, OP_RTYPE, 0, 0, 0, 0);
    cyc("idle_run", 0, 1, 1, 0, OP_RTYPE, 0, 0, 0, 0);
    cyc("r_fetch", 0, 1, 1, 0, OP_RTYPE, 1, FI, 0, 0);
    cyc("r_decode", 0, 1, 1, 0, OP_RTYPE, 2, 0, 0, 0);
    cyc("r_exec", 0, 1, 1, 0, OP_RTYPE, 3, 0, ALU_FUNCT, 0);
    cyc("r_wb", 0, 1, 1, 0, OP_RTYPE, 7, RFWE | RFDST, 0, 0);
    cyc("lw_fetch", 0, 1, 1, 0, OP_LW, 1, FI, 0, 1);
    cyc("lw_decode", 0, 1, 0, 0, OP_LW, 2, 0, 0, 1);
    cyc("lw_exec", 0, 1, 0, 0, OP_LW, 4, ALUB, ALU_ADD, 1);
    cyc("lw_mem_w1", 0, 1, 0, 0, OP_LW, 6, MREQ | MADDR, 0, 1);
    cyc("lw_mem_w2", 0, 1, 0, 0, OP_LW, 6, MREQ | MADDR, 0, 1);
    cyc("lw_mem_rdy", 0, 1, 1, 0, OP_LW, 6, MREQ | MADDR, 0, 1);
    cyc("lw_wb", 0, 1, 1, 0, OP_LW, 7, RFWE | RFWD, 0, 1);
    cyc("beq_fetch", 0, 1, 1, 1, OP_BEQ, 1, FI, 0, 2);
    cyc("beq_decode", 0, 1, 1, 1, OP_BEQ, 2, 0, 0, 2);
    cyc("beq_taken", 0, 1, 1, 1, OP_BEQ, 5, PCWE | PCSRC, ALU_SUB, 2);
    cyc("beq2_fetch", 0, 1, 1, 0, OP_BEQ, 1, FI, 0, 3);
    cyc("beq2_decode", 0, 1, 1, 0, OP_BEQ, 2, 0, 0, 3);
    cyc("beq_not_taken", 0, 1, 1, 0, OP_BEQ, 5, PCSRC, ALU_SUB, 3);
    cyc("sw_fetch_wait", 0, 1, 0, 0, OP_SW, 1, MREQ, 0, 0);
    cyc("sw_fetch", 0, 1, 1, 0, OP_SW, 1, FI, 0, 0);
    cyc("sw_decode", 0, 1, 1, 0, OP_SW, 2, 0, 0, 0);
    cyc("sw_exec", 0, 1, 1, 0, OP_SW, 4, ALUB, ALU_ADD, 0);
    cyc("sw_mem_wait", 0, 1, 0, 0, OP_SW, 6, MREQ | MADDR | MWE, 0, 0);
    cyc("sw_mem_rdy", 0, 1, 1, 0, OP_SW, 6, MREQ | MADDR | MWE, 0, 0);
    cyc("r2_fetch", 0, 1, 1, 0, OP_RTYPE, 1, FI, 0, 1);
    cyc("r2_decode", 0, 1, 1, 0, OP_RTYPE, 2, 0, 0, 1);
    cyc("r2_exec_stop", 0, 0, 1, 0, OP_RTYPE, 3, 0, ALU_FUNCT, 1);
    cyc("r2_wb", 0, 0, 1, 0, OP_RTYPE, 7, RFWE | RFDST, 0, 1);
    cyc("stop_idle", 0, 0, 1, 0, OP_RTYPE, 0, 0, 0, 2);
    cyc("stop_hold", 0, 0, 1, 0, OP_BAD, 0, 0, 0, 2);
    cyc("ill_start", 0, 1, 1, 0, OP_BAD, 0, 0, 0, 2);
    cyc("ill_fetch", 0, 1, 1, 0, OP_BAD, 1, FI, 0, 2);
    cyc("ill_decode", 0, 0, 1, 0, OP_BAD, 2, 0, 0, 2);
    cyc("trap", 0, 0, 1, 0, OP_BAD, 0, ILL, 0, 2);
    cyc("trap_run", 0, 1, 1, 0, OP_BAD, 0, ILL, 0, 2);
    cyc("trap_reset", 1, 1, 1, 0, OP_BAD, 0, ILL, 0, 2);
    cyc("after_trap", 0, 1, 0, 0, OP_RTYPE, 0, 0, 0, 0);
    cyc("fetch_wait", 0, 1, 0, 0, OP_RTYPE, 1, MREQ, 0, 0);
    cyc("fetch_reset", 1, 1, 0, 0, OP_RTYPE, 1, MREQ, 0, 0);
    cyc("fetch_reset_idle", 0, 0, 0, 0, OP_RTYPE, 0, 0, 0, 0);
    cyc("nop_idle", 0, 1, 1, 0, OP_BAD, 0, 0, 0, 0, 1, 1);
    cyc("nop_fetch", 0, 1, 1, 0, OP_BAD, 1, FI, 0, 0, 1, 1);
    cyc("nop_decode", 0, 0, 1, 0, OP_BAD, 2, 0, 0, 0, 1, 1);
    cyc("nop_retired", 0, 0, 1, 0, OP_BAD, 0, ILL, 0, 1, 1, 1);
    @(negedge clk);
    #3;
    done = 1'b1;
    checks++;
    if (q.size() != 0 || checks < 40) begin
      errors++;
      $error("FAIL end: %0d expectations pending, %0d checks run", q.size(), checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the 32-bit MIPS datapath: sequences fetch, decode, execute, memory and writeback over several clocks.
- Replaces the per-opcode combinational steering block with explicit, registered instruction phases and a ready/request handshake to a shared instruction/data memory port.
- Drives the mux selects, PC/IR/register-file/memory enables and the ALU operation class.
- Supports R-type (000000), lw (100011), sw (101011) and beq (000100); traps any other opcode.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- ILLEGAL_HALT, 1, 1 = illegal opcode enters TRAP; 0 = illegal opcode is treated as a NOP and execution continues.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR.
- pc_we  out  1  load PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- rf_we  out  1  register-file write.
- rf_dst_sel  out  1  0 = rt, 1 = rd.
- rf_wdata_sel  out  1  0 = ALU, 1 = memory data.
- alu_src_b  out  1  0 = rt, 1 = sign-extended immediate.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct.
- illegal  out  1  sticky illegal-opcode flag.
- busy  out  1  state != IDLE and state != TRAP.
- state_dbg  out  3  current state encoding.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: the already-decided scheme is reset reset, synchronous, active-high.
  - Forces state to IDLE, illegal to 0, retired to 0.
  - All enables and selects are 0 in IDLE.
  - Reset takes priority over every other event, including mid-memory-access; mem_req drops the cycle after the reset edge.
- Output style:
  - Outputs decode from state (Moore).
  - Exceptions: ir_we, pc_we in FETCH and MEM-phase advance depend on mem_ready; pc_we in EXEC_BEQ depends on alu_zero.
- IDLE: run=1 -> FETCH.
- FETCH:
  - Drives mem_req=1, mem_addr_sel=0, mem_we=0.
  - Holds while mem_ready=0 (unbounded wait).
  - On mem_ready=1 in the same cycle: ir_we=1, pc_we=1, pc_src=0, then -> DECODE.
- DECODE: one cycle, register read, no enables.
  - 000000 -> EXEC_R.
  - 100011 or 101011 -> EXEC_MEM.
  - 000100 -> EXEC_BEQ.
  - Any other opcode: ILLEGAL_HALT=1 -> TRAP; ILLEGAL_HALT=0 -> retire and go to FETCH/IDLE per run.
- EXEC_R: alu_src_b=0, alu_op=10 -> WB.
- EXEC_MEM: alu_src_b=1, alu_op=00 -> MEM.
- EXEC_BEQ:
  - Drives alu_src_b=0, alu_op=01, pc_src=1, pc_we=alu_zero.
  - Retires the instruction, then -> FETCH/IDLE per run.
- MEM:
  - Drives mem_req=1, mem_addr_sel=1, mem_we=(opcode==101011).
  - Holds until mem_ready.
  - sw: retires on mem_ready, then -> FETCH/IDLE.
  - lw: -> WB.
- WB:
  - Drives rf_we=1.
  - R-type: rf_dst_sel=1, rf_wdata_sel=0.
  - lw: rf_dst_sel=0, rf_wdata_sel=1.
  - Retires, then -> FETCH/IDLE.
- TRAP: illegal=1, no enables, stays until reset. run has no effect.
- Run/stop: run is sampled only at retirement. run=0 at retirement -> IDLE; otherwise -> FETCH. Deasserting run mid-instruction never aborts the instruction.
- Latency with zero wait states: R 4, lw 5, sw 4, beq 3 cycles. Each wait cycle adds 1.
- retired increments by 1 on the retirement cycle and wraps modulo 2^CNT_W.
- mem_req never rises in DECODE, EXEC_* or WB.
- IR is stable from DECODE until the next FETCH completes.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - state enum with encodings IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_MEM=4, EXEC_BEQ=5, MEM=6, WB=7; TRAP takes a 4th state bit or shares encoding via an illegal qualifier (implementation choice). state_dbg reports the low 3 bits.
  - ALU_ADD/ALU_SUB/ALU_FUNCT codes.
- One sub-module, mips_op_decode: combinational opcode -> {class, is_store, is_load, legal}. Reused later by a pipelined core.

Test Plan:
- Reset, run=1, zero wait, R-type opcode 000000 -> states 1,2,3,7,1. rf_we=1 with rf_dst_sel=1 for exactly 1 cycle. retired=1 after 4 cycles.
- lw with mem_ready low for 2 cycles in MEM -> mem_req=1, mem_addr_sel=1, mem_we=0 held 3 cycles. WB asserts rf_wdata_sel=1 and rf_dst_sel=0. Total 7 cycles.
- beq: alu_zero=1 -> pc_we=1 with pc_src=1 in EXEC_BEQ. Repeat with alu_zero=0 -> pc_we=0. Both take 3 cycles.
- sw -> mem_we=1 only while in MEM; rf_we never asserted. retired increments on mem_ready.
- Opcode 111111 with ILLEGAL_HALT=1 -> TRAP, illegal=1, busy=0. Toggling run has no effect. Reset -> IDLE, illegal=0.
- Two further cases: run dropped during EXEC_R -> WB completes, then IDLE with retired+1. Reset asserted mid-FETCH wait -> IDLE next cycle, mem_req=0, retired=0. CNT_W=2 wrap check: 4 retirements -> retired=0.
